axis_pkt_rr_arbiter: RTL and testbench
======================================

// Module: axis_pkt_rr_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter that shares one 8-bit AXI-Stream register slice between NUM_SRC upstream masters.
//  Grants one source at a time and passes its beats through combinationally to the slice's s_* input.
//  Holds the grant until that packet's last beat completes.
//  Enforces a maximum packet length so a stuck source cannot hold the shared slice forever.
// PARAMETERS
//  NUM_SRC   4    number of requesting stream sources (2..8)
//  DATA_W    8    tdata width per source
//  MAX_BEATS 256  max beats per packet; the packet is truncated at this beat
// PORTS
//  clk        in   1                  clock, rising edge
//  resetn     in   1                  asynchronous active-low reset
//  s_data     in   NUM_SRC*DATA_W     source data, src i at [i*DATA_W +: DATA_W]
//  s_valid    in   NUM_SRC            per-source valid
//  s_last     in   NUM_SRC            per-source last
//  s_ready    out  NUM_SRC            per-source ready (at most one bit high)
//  m_data     out  DATA_W             to register-slice s_data
//  m_valid    out  1                  to register-slice s_valid
//  m_last     out  1                  to register-slice s_last
//  m_ready    in   1                  from register-slice s_ready
//  grant_id   out  clog2(NUM_SRC)     currently/last granted source
//  busy       out  1                  1 while in state XFER
//  trunc_err  out  1                  1-cycle pulse when a packet is truncated
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - state=IDLE; ptr=NUM_SRC-1, so src0 has first priority.
//   - grant_id=0, busy=0, trunc_err=0, beat_cnt=0.
//   - m_valid=0, s_ready=0 (outputs are combinational from state, so all low while in IDLE).
//  State machine: IDLE, XFER.
//  IDLE:
//   - m_valid=0, m_last=0, m_data=0, s_ready=0.
//   - If any s_valid, register gnt = the first requester searching ptr+1, ptr+2, ... (mod NUM_SRC).
//   - Then go to XFER and clear beat_cnt. Arbitration latency is 1 cycle.
//  XFER, with g=gnt:
//   - m_data=s_data[g], m_valid=s_valid[g], s_ready[g]=m_ready; all other s_ready bits are 0.
//   - m_last = s_last[g] | (beat_cnt==MAX_BEATS-1).
//   - A beat transfers when s_valid[g] & m_ready. Each beat increments beat_cnt (width clog2(MAX_BEATS+1), no wrap reachable).
//   - Beat with m_last=1: set ptr<=g, go to IDLE.
//   - If that beat was forced (s_last[g]=0), pulse trunc_err for the next cycle.
//   - The remaining beats of a truncated packet re-arbitrate as a new packet.
//   - Exactly one bubble cycle (IDLE) between consecutive packets.
//  Other rules:
//   - The grant never changes mid-packet, regardless of other s_valid activity.
//   - s_valid[g] dropping mid-packet only stalls; the grant is held.
//   - m_ready low holds all state; the data path is pure pass-through, with no storage here.
//   - Simultaneous requests resolve strictly round-robin from ptr. A lone requester may win repeatedly.
//   - grant_id=gnt at all times; it holds its last value in IDLE.
//   - Reset asserted mid-packet: the packet is abandoned immediately and the downstream slice is reset by the same resetn.
// TESTING
//  1. src0..3 all valid with 2-beat packets from reset, m_ready=1 -> grant order 0,1,2,3,0; 1 bubble between packets; busy matches XFER.
//  2. Only src2 requests, 3-beat packets x2 -> both granted to src2; s_ready=4'b0100 during beats; m_data matches src2 data.
//  3. src1 in XFER with 4-beat packet, src0 asserts valid at beat 2 -> src1 completes all 4 beats before src0 is granted.
//  4. m_ready toggles 1,0,0,1 during a src3 packet -> beats transfer only on m_ready=1 cycles; no beat lost or duplicated.
//  5. src0 sends 300 beats with s_last=0, MAX_BEATS=256 -> m_last=1 on beat 256, trunc_err pulses once, the rest re-arbitrates as a new packet.
//  6. resetn low mid-packet at beat 1 of src2 -> m_valid=0, s_ready=0 asynchronously; next grant after release goes to src0.

Source files
------------

// File: rtl/axis_pkt_rr_arbiter.sv
// axis_pkt_rr_arbiter: packet-atomic round-robin arbiter feeding one shared AXI-Stream slice,
// with a maximum packet length that force-terminates runaway packets.
module axis_pkt_rr_arbiter #(
  parameter  int NUM_SRC   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BEATS = 256,
  localparam int IDW       = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_SRC*DATA_W-1:0] s_data,
  input  logic [NUM_SRC-1:0]        s_valid,
  input  logic [NUM_SRC-1:0]        s_last,
  output logic [NUM_SRC-1:0]        s_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      trunc_err
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t         state_q, state_d;
  logic [IDW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, pick;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           trunc_q, trunc_d, found, xfer, beat;
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!found && s_valid[(int'(ptr_q) + k) % NUM_SRC]) begin
        pick  = IDW'((int'(ptr_q) + k) % NUM_SRC);
        found = 1'b1;
      end
    end
  end
  assign xfer      = state_q == XFER;
  assign m_valid   = xfer & s_valid[gnt_q];
  assign m_last    = xfer & (s_last[gnt_q] | (cnt_q == CW'(MAX_BEATS - 1)));
  assign m_data    = xfer ? s_data[gnt_q*DATA_W +: DATA_W] : '0;
  assign s_ready   = xfer ? (NUM_SRC'(m_ready) << gnt_q) : '0;
  assign beat      = m_valid & m_ready;
  assign grant_id  = gnt_q;
  assign busy      = xfer;
  assign trunc_err = trunc_q;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    if (!xfer) begin
      if (found) begin
        gnt_d   = pick;
        cnt_d   = '0;
        state_d = XFER;
      end
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
      if (m_last) begin
        // a last beat without the source's own s_last is a forced truncation
        ptr_d   = gnt_q;
        state_d = IDLE;
        trunc_d = ~s_last[gnt_q];
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= IDW'(NUM_SRC - 1);
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end
endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// tb_axis_pkt_rr_arbiter: table-driven per-cycle vectors for arbitration order and grant hold,
// plus directed sequences for backpressure, truncation and mid-packet reset.
module tb_axis_pkt_rr_arbiter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_valid = '0, s_last = '0, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_ready = 1'b0;
  logic [1:0]  grant_id;
  logic        busy, trunc_err;
  int          n_chk = 0, n_fail = 0;

  axis_pkt_rr_arbiter #(.NUM_SRC(4), .DATA_W(8), .MAX_BEATS(256)) dut (
    .clk(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .grant_id(grant_id), .busy(busy), .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sv, sl;
    logic       mr, ev, el;
    logic [3:0] esr;
    logic [7:0] emd;
    logic [1:0] egid;
    logic       eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [3:0] sv, sl, input logic mr, ev, el,
                             input logic [3:0] esr, input logic [7:0] emd,
                             input logic [1:0] egid, input logic eb);
    vec_t r;
    r.sv = sv; r.sl = sl; r.mr = mr; r.ev = ev; r.el = el;
    r.esr = esr; r.emd = emd; r.egid = egid; r.eb = eb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int k;
    int mr4[5] = '{1, 0, 0, 1, 1};
    logic [7:0] md4[5] = '{8'hC0, 8'hC1, 8'hC1, 8'hC1, 8'hC2};
    logic [3:0] sr4[5] = '{4'h8, 4'h0, 4'h0, 4'h8, 4'h8};
    logic ml4[5] = '{0, 0, 0, 0, 1};
    int tr_cnt;
    // round-robin over all four sources with 2-beat packets
    tbl.push_back(v(4'hF, 4'h0, 1, 0, 0, 4'h0, 8'h00, 0, 0));
    tbl.push_back(v(4'hF, 4'h0, 1, 1, 0, 4'h1, 8'h11, 0, 1));
    tbl.push_back(v(4'hF, 4'h1, 1, 1, 1, 4'h1, 8'h11, 0, 1));
    tbl.push_back(v(4'hF, 4'h0, 1, 0, 0, 4'h0, 8'h00, 0, 0));
    tbl.push_back(v(4'hF, 4'h0, 1, 1, 0, 4'h2, 8'h22, 1, 1));
    tbl.push_back(v(4'hF, 4'h2, 1, 1, 1, 4'h2, 8'h22, 1, 1));
    tbl.push_back(v(4'hF, 4'h0, 1, 0, 0, 4'h0, 8'h00, 1, 0));
    tbl.push_back(v(4'hF, 4'h0, 1, 1, 0, 4'h4, 8'h33, 2, 1));
    tbl.push_back(v(4'hF, 4'h4, 1, 1, 1, 4'h4, 8'h33, 2, 1));
    tbl.push_back(v(4'hF, 4'h0, 1, 0, 0, 4'h0, 8'h00, 2, 0));
    tbl.push_back(v(4'hF, 4'h0, 1, 1, 0, 4'h8, 8'h44, 3, 1));
    tbl.push_back(v(4'hF, 4'h8, 1, 1, 1, 4'h8, 8'h44, 3, 1));
    tbl.push_back(v(4'hF, 4'h0, 1, 0, 0, 4'h0, 8'h00, 3, 0));
    tbl.push_back(v(4'hF, 4'h0, 1, 1, 0, 4'h1, 8'h11, 0, 1));
    tbl.push_back(v(4'hF, 4'h1, 1, 1, 1, 4'h1, 8'h11, 0, 1));
    // lone src2, two 3-beat packets; valid drop mid-packet only stalls
    tbl.push_back(v(4'h4, 4'h0, 1, 0, 0, 4'h0, 8'h00, 0, 0));
    tbl.push_back(v(4'h4, 4'h0, 1, 1, 0, 4'h4, 8'h33, 2, 1));
    tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 4'h4, 8'h33, 2, 1));
    tbl.push_back(v(4'h4, 4'h0, 1, 1, 0, 4'h4, 8'h33, 2, 1));
    tbl.push_back(v(4'h4, 4'h4, 1, 1, 1, 4'h4, 8'h33, 2, 1));
    tbl.push_back(v(4'h4, 4'h0, 1, 0, 0, 4'h0, 8'h00, 2, 0));
    tbl.push_back(v(4'h4, 4'h0, 1, 1, 0, 4'h4, 8'h33, 2, 1));
    tbl.push_back(v(4'h4, 4'h0, 1, 1, 0, 4'h4, 8'h33, 2, 1));
    tbl.push_back(v(4'h4, 4'h4, 1, 1, 1, 4'h4, 8'h33, 2, 1));
    // src1 4-beat packet, src0 arrives mid-packet and must wait
    tbl.push_back(v(4'h2, 4'h0, 1, 0, 0, 4'h0, 8'h00, 2, 0));
    tbl.push_back(v(4'h2, 4'h0, 1, 1, 0, 4'h2, 8'h22, 1, 1));
    tbl.push_back(v(4'h3, 4'h0, 1, 1, 0, 4'h2, 8'h22, 1, 1));
    tbl.push_back(v(4'h3, 4'h0, 1, 1, 0, 4'h2, 8'h22, 1, 1));
    tbl.push_back(v(4'h3, 4'h2, 1, 1, 1, 4'h2, 8'h22, 1, 1));
    tbl.push_back(v(4'h1, 4'h0, 1, 0, 0, 4'h0, 8'h00, 1, 0));
    tbl.push_back(v(4'h1, 4'h1, 1, 1, 1, 4'h1, 8'h11, 0, 1));
    tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 4'h0, 8'h00, 0, 0));
    tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 4'h0, 8'h00, 0, 0));

    #1;
    chk("rst_m_valid", {31'b0, m_valid}, 0);
    chk("rst_s_ready", {28'b0, s_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_grant", {30'b0, grant_id}, 0);
    chk("rst_trunc", {31'b0, trunc_err}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      s_valid = tbl[i].sv; s_last = tbl[i].sl; m_ready = tbl[i].mr; s_data = 32'h44332211;
      #1;
      chk($sformatf("t%0d_m_valid", i), {31'b0, m_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("t%0d_m_last", i), {31'b0, m_last}, {31'b0, tbl[i].el});
      chk($sformatf("t%0d_s_ready", i), {28'b0, s_ready}, {28'b0, tbl[i].esr});
      chk($sformatf("t%0d_m_data", i), {24'b0, m_data}, {24'b0, tbl[i].emd});
      chk($sformatf("t%0d_grant", i), {30'b0, grant_id}, {30'b0, tbl[i].egid});
      chk($sformatf("t%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].eb});
      chk($sformatf("t%0d_trunc", i), {31'b0, trunc_err}, 0);
      @(negedge clk);
    end

    // src3 packet under m_ready pattern 1,0,0,1,1
    s_valid = 4'h8; s_last = 4'h0; m_ready = 1'b1; s_data = {8'hC0, 24'h0};
    #1 chk("bp_idle_busy", {31'b0, busy}, 0);
    @(negedge clk);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      m_ready = mr4[i][0];
      s_data = {8'(8'hC0 + k), 24'h0};
      s_last = (k == 2) ? 4'h8 : 4'h0;
      #1;
      chk($sformatf("bp%0d_m_data", i), {24'b0, m_data}, {24'b0, md4[i]});
      chk($sformatf("bp%0d_s_ready", i), {28'b0, s_ready}, {28'b0, sr4[i]});
      chk($sformatf("bp%0d_m_last", i), {31'b0, m_last}, {31'b0, ml4[i]});
      chk($sformatf("bp%0d_grant", i), {30'b0, grant_id}, 3);
      if (mr4[i] == 1) k++;
      @(negedge clk);
    end
    s_valid = 4'h0; s_last = 4'h0; m_ready = 1'b1;
    #1;
    chk("bp_end_busy", {31'b0, busy}, 0);
    chk("bp_end_grant", {30'b0, grant_id}, 3);
    @(negedge clk);

    // src0 300-beat packet without s_last: forced last on beat 256
    tr_cnt = 0;
    s_valid = 4'h1; s_last = 4'h0; m_ready = 1'b1;
    #1 chk("tr_idle_busy", {31'b0, busy}, 0);
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      s_data = {24'h0, 8'(i)};
      #1;
      if (trunc_err) tr_cnt++;
      chk($sformatf("tr_a%0d_m_last", i), {31'b0, m_last}, (i == 255) ? 1 : 0);
      chk($sformatf("tr_a%0d_m_data", i), {24'b0, m_data}, i & 255);
      if (i == 0) chk("tr_a_grant", {30'b0, grant_id}, 0);
      @(negedge clk);
    end
    #1;
    chk("tr_bubble_busy", {31'b0, busy}, 0);
    chk("tr_pulse", {31'b0, trunc_err}, 1);
    if (trunc_err) tr_cnt++;
    @(negedge clk);
    for (int j = 0; j < 44; j++) begin
      s_data = {24'h0, 8'(256 + j)};
      s_last = (j == 43) ? 4'h1 : 4'h0;
      #1;
      if (trunc_err) tr_cnt++;
      chk($sformatf("tr_b%0d_busy", j), {31'b0, busy}, 1);
      chk($sformatf("tr_b%0d_m_last", j), {31'b0, m_last}, (j == 43) ? 1 : 0);
      chk($sformatf("tr_b%0d_m_data", j), {24'b0, m_data}, j);
      @(negedge clk);
    end
    s_valid = 4'h0; s_last = 4'h0;
    #1;
    if (trunc_err) tr_cnt++;
    chk("tr_end_busy", {31'b0, busy}, 0);
    chk("tr_pulse_count", tr_cnt, 1);
    @(negedge clk);

    // reset during the first beat of a src2 packet
    s_valid = 4'h4; s_data = 32'h44332211;
    @(negedge clk);
    #1;
    chk("rs_pre_grant", {30'b0, grant_id}, 2);
    chk("rs_pre_valid", {31'b0, m_valid}, 1);
    resetn = 1'b0;
    #1;
    chk("rs_m_valid", {31'b0, m_valid}, 0);
    chk("rs_s_ready", {28'b0, s_ready}, 0);
    chk("rs_busy", {31'b0, busy}, 0);
    chk("rs_grant", {30'b0, grant_id}, 0);
    @(negedge clk);
    s_valid = 4'h5;
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("rs_next_grant", {30'b0, grant_id}, 0);
    chk("rs_next_s_ready", {28'b0, s_ready}, 1);
    chk("rs_next_m_data", {24'b0, m_data}, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
